// File: rtl/text_fill_ctrl_if.sv
// Write-port bundle between the text fill controller and the character RAM / character source.
// The master side is the controller; the slave side is the RAM plus upstream generator.
interface text_fill_ctrl_if #(
  parameter int char_width = 7,
  parameter int addr_width = 13
);
  logic                  run;
  logic [char_width-1:0] char_in;
  logic                  wr_ready;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [char_width-1:0] wr_data;
  logic                  busy;
  logic                  wrap;

  modport master (
    input  run, char_in, wr_ready,
    output wr_en, wr_addr, wr_data, busy, wrap
  );

  modport slave (
    output run, char_in, wr_ready,
    input  wr_en, wr_addr, wr_data, busy, wrap
  );
endinterface

// File: rtl/text_fill_ctrl.sv
// Paced random-text screen filler: writes one character per rate_div counted cycles, raster order.
// Define TEXT_FILL_CLEAR_EN to zero the whole screen after reset and after every cursor wrap.
module text_fill_ctrl #(
  parameter int char_width = 7,
  parameter int cols       = 128,
  parameter int rows       = 48,
  parameter int rate_div   = 1024
) (
  input  logic             clk,
  input  logic             reset,
  text_fill_ctrl_if.master bus
);
  localparam int cells      = cols * rows;
  localparam int addr_width = (cells > 1) ? $clog2(cells) : 1;
  localparam int cnt_width  = (rate_div > 1) ? $clog2(rate_div) : 1;

  localparam logic [addr_width-1:0] last_addr = addr_width'(cells - 1);
  localparam logic [cnt_width-1:0]  last_cnt  = cnt_width'(rate_div - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

`ifdef TEXT_FILL_CLEAR_EN
  localparam state_t reset_state = CLEAR;
`else
  localparam state_t reset_state = WAIT;
`endif

  state_t                state_q, state_d;
  logic [cnt_width-1:0]  cnt_q, cnt_d;
  logic [addr_width-1:0] cursor_q, cursor_d;
  logic [char_width-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wrap_q, wrap_d;
  logic                  accept;

  // Modulo increments; explicit compare keeps non-power-of-two ranges in bounds.
  function automatic logic [addr_width-1:0] inc_addr(input logic [addr_width-1:0] a);
    return (a == last_addr) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [cnt_width-1:0] inc_cnt(input logic [cnt_width-1:0] c);
    return (c == last_cnt) ? '0 : c + 1'b1;
  endfunction

  assign accept = wr_en_q && bus.wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= reset_state;
      cnt_q    <= '0;
      cursor_q <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    data_d   = data_q;
    wr_en_d  = wr_en_q;
    wrap_d   = 1'b0;

    case (state_q)
      WAIT: begin
        if (bus.run) begin
          cnt_d = inc_cnt(cnt_q);
          if (cnt_q == last_cnt) begin
            data_d  = bus.char_in;
            wr_en_d = 1'b1;
            state_d = WRITE;
          end
        end
      end

      // Address and data stay frozen until the RAM accepts; run and char_in are ignored here.
      WRITE: begin
        if (accept) begin
          wr_en_d  = 1'b0;
          cnt_d    = '0;
          cursor_d = inc_addr(cursor_q);
          state_d  = WAIT;
          if (cursor_q == last_addr) begin
            wrap_d = 1'b1;
`ifdef TEXT_FILL_CLEAR_EN
            state_d = CLEAR;
            wr_en_d = 1'b1;
            data_d  = '0;
`endif
          end
        end
      end

`ifdef TEXT_FILL_CLEAR_EN
      // Back-to-back zero writes; the cursor doubles as the clear address.
      CLEAR: begin
        data_d  = '0;
        wr_en_d = 1'b1;
        if (accept) begin
          cursor_d = inc_addr(cursor_q);
          if (cursor_q == last_addr) begin
            wr_en_d = 1'b0;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
`endif

      default: begin
        state_d = WAIT;
        wr_en_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = cursor_q;
  assign bus.wr_data = data_q;
  assign bus.wrap    = wrap_q;

`ifdef TEXT_FILL_CLEAR_EN
  assign bus.busy = (state_q == CLEAR);
`else
  assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_text_fill_ctrl.sv
// Randomized bench for text_fill_ctrl (cols=4, rows=2, rate_div=4) against a behavioural screen model.
// Follows TEXT_FILL_CLEAR_EN the same way the design does.
module tb_text_fill_ctrl;
  localparam int char_w   = 7;
  localparam int n_cols   = 4;
  localparam int n_rows   = 2;
  localparam int div      = 4;
  localparam int n_cells  = n_cols * n_rows;
  localparam int a_w      = 3;

`ifdef TEXT_FILL_CLEAR_EN
  localparam bit clear_en = 1'b1;
`else
  localparam bit clear_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_fill_ctrl_if #(.char_width(char_w), .addr_width(a_w)) bus ();

  text_fill_ctrl #(
    .char_width(char_w),
    .cols      (n_cols),
    .rows      (n_rows),
    .rate_div  (div)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model of what the screen writer is doing right now.
  bit clearing;      // zero-fill pass in progress
  bit req;           // a write is being offered to the RAM
  int pos;           // cell currently addressed
  int ticks;         // counted run cycles since the last character write
  int ch;            // value currently offered as write data
  bit wrapped;       // cursor went back to cell 0 on the last edge

  int acc_cyc[$];
  int acc_addr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Screen-writer behaviour for one clock edge.
  task automatic model_edge(input bit r, input bit go, input int c, input bit rdy);
    bit took;
    wrapped = 1'b0;
    if (r) begin
      clearing = clear_en;
      req      = 1'b0;
      pos      = 0;
      ticks    = 0;
      ch       = 0;
      return;
    end
    took = req && rdy;
    if (clearing) begin
      ch = 0;
      if (took && pos == n_cells - 1) begin
        clearing = 1'b0;
        req      = 1'b0;
        pos      = 0;
        ticks    = 0;
      end else begin
        if (took) pos = pos + 1;
        req = 1'b1;
      end
    end else if (req) begin
      if (took) begin
        req   = 1'b0;
        ticks = 0;
        pos   = (pos + 1) % n_cells;
        if (pos == 0) begin
          wrapped = 1'b1;
          if (clear_en) begin
            clearing = 1'b1;
            req      = 1'b1;
            ch       = 0;
          end
        end
      end
    end else if (go) begin
      ticks = ticks + 1;
      if (ticks == div) begin
        ticks = 0;
        ch    = c;
        req   = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit go, input int c, input bit rdy);
    reset       = r;
    bus.run     = go;
    bus.char_in = c[char_w-1:0];
    bus.wr_ready = rdy;
    if (!r && bus.wr_en && rdy && !bus.busy) begin
      acc_cyc.push_back(cyc);
      acc_addr.push_back(int'(bus.wr_addr));
    end
    @(posedge clk);
    model_edge(r, go, c & 32'h7f, rdy);
    cyc++;
    #1;
    check("wr_en",   32'(bus.wr_en),   32'(req));
    check("wr_addr", 32'(bus.wr_addr), 32'(pos));
    check("wr_data", 32'(bus.wr_data), 32'(ch));
    check("wrap",    32'(bus.wrap),    32'(wrapped));
    check("busy",    32'(bus.busy),    32'(clearing));
  endtask

  // Advance until a character write is on offer; bounded.
  task automatic run_to_char_write(input string tag);
    int n = 0;
    while (!(req && !clearing) && n < 200) begin
      cycle(1'b0, 1'b1, $urandom_range(0, 127), 1'b1);
      n++;
    end
    check(tag, 32'(req && !clearing), 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.char_in  = '0;
    bus.wr_ready = 1'b0;

    // Reset, then free-running fill with the RAM always ready.
    repeat (3) cycle(1'b1, 1'b0, 0, 1'b0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'(clear_en));
    repeat (60) cycle(1'b0, 1'b1, 'h41, 1'b1);

    // Steady-state spacing of character writes.
    acc_cyc.delete();
    acc_addr.delete();
    repeat (100) cycle(1'b0, 1'b1, $urandom_range(0, 127), 1'b1);
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_addr[i-1] != n_cells - 1)
        check("period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(div + 1));
    check("period_seen", 32'(acc_cyc.size() >= 10), 32'd1);

    // RAM stalls a character write while char_in toggles and run drops.
    run_to_char_write("wait_write_stall");
    for (int i = 0; i < 5; i++)
      cycle(1'b0, i[0], (i % 2 == 0) ? 'h5A : 'h41, 1'b0);
    cycle(1'b0, 1'b1, 'h5A, 1'b1);
    check("stall_accepted", 32'(bus.wr_en && !bus.busy), 32'd0);

    // Pause the pacing counter part way through.
    repeat (2) cycle(1'b0, 1'b1, 'h33, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 'h33, 1'b1);
    repeat (8) cycle(1'b0, 1'b1, 'h33, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 700; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 127), $urandom_range(0, 9) < 7);

    // Reset while a write is stalled.
    run_to_char_write("wait_write_reset");
    cycle(1'b0, 1'b1, 'h11, 1'b0);
    cycle(1'b1, 1'b1, 'h11, 1'b0);
    check("rst_mid_wr_en",   32'(bus.wr_en),   32'd0);
    check("rst_mid_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_mid_wrap",    32'(bus.wrap),    32'd0);
    repeat (60) cycle(1'b0, 1'b1, $urandom_range(0, 127), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
